// File: rtl/inv_seq_ctrl.sv
// ----------------------------------------------------------------------------
// inv_seq_ctrl
//
// Clocked, self-checking sequencer for a single inverter or buffer cell under
// test. It drives the cell input with a square wave whose half-period and
// number of windows are programmable. At the end of every window it samples
// the cell output and compares it with the value expected for the selected
// mode. It reports a one-cycle done pulse, a sticky error flag and a
// saturating mismatch count.
//
// Ports:
//   clk          - system clock, rising edge
//   rst_n        - asynchronous active-low reset
//   start        - run request, only honoured while idle
//   half_period  - cycles dut_a is held before the check cycle (latched)
//   num_windows  - number of drive/check windows (latched)
//   mode         - 0 = inverter (expect y = ~a), 1 = buffer (expect y = a)
//   dut_a        - drive to the cell input
//   dut_y        - cell output, assumed settled (no synchroniser)
//   busy         - high whenever the sequencer is not idle
//   done         - one-cycle pulse at the end of a run
//   err          - sticky mismatch flag, cleared by the next accepted start
//   mismatch_cnt - mismatches in the current/last run, saturating at all-ones
// ----------------------------------------------------------------------------
module inv_seq_ctrl #(
    parameter int HP_W = 16,
    parameter int NW_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [HP_W-1:0] half_period,
    input  logic [NW_W-1:0] num_windows,
    input  logic            mode,
    output logic            dut_a,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [NW_W-1:0] mismatch_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        CHECK,
        FIN
    } state_t;

    state_t          state_q;
    logic [HP_W-1:0] cnt_q;
    logic [NW_W-1:0] win_q;
    logic [HP_W-1:0] hp_q;
    logic [NW_W-1:0] nw_q;
    logic            mode_q;
    logic            dut_a_q;
    logic            err_q;
    logic [NW_W-1:0] mcnt_q;
    logic            expected_y;

    // The value the cell should present for the level currently driven.
    // A buffer echoes its input, an inverter complements it.
    assign expected_y = mode_q ? dut_a_q : ~dut_a_q;

    // Status outputs come straight from the registered state, so they are
    // glitch-free. FIN is the only state in which done is high.
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == FIN);
    assign dut_a        = dut_a_q;
    assign err          = err_q;
    assign mismatch_cnt = mcnt_q;

    // Main sequencer. HOLD counts cnt_q down from half_period-1 to 0, which
    // gives half_period cycles. The single CHECK cycle follows, so every
    // window holds dut_a for half_period+1 cycles. The cell output is
    // sampled on the edge that leaves CHECK. The run settings are latched at
    // start so that input changes during a run have no effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            win_q   <= '0;
            hp_q    <= '0;
            nw_q    <= '0;
            mode_q  <= 1'b0;
            dut_a_q <= 1'b0;
            err_q   <= 1'b0;
            mcnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_q   <= 1'b0;
                        mcnt_q  <= '0;
                        dut_a_q <= 1'b0;
                        // A zero-length run goes straight to FIN. No
                        // windows are driven in that case.
                        if ((half_period != '0) && (num_windows != '0)) begin
                            hp_q    <= half_period;
                            nw_q    <= num_windows;
                            mode_q  <= mode;
                            cnt_q   <= half_period - HP_W'(1);
                            win_q   <= '0;
                            state_q <= HOLD;
                        end else begin
                            state_q <= FIN;
                        end
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= CHECK;
                    end else begin
                        cnt_q <= cnt_q - HP_W'(1);
                    end
                end
                CHECK: begin
                    if (dut_y != expected_y) begin
                        err_q <= 1'b1;
                        if (mcnt_q != '1) begin
                            mcnt_q <= mcnt_q + NW_W'(1);
                        end
                    end
                    // After the last window dut_a is left as it was.
                    // Otherwise it toggles to start the next window.
                    if (win_q == nw_q - NW_W'(1)) begin
                        state_q <= FIN;
                    end else begin
                        dut_a_q <= ~dut_a_q;
                        cnt_q   <= hp_q - HP_W'(1);
                        win_q   <= win_q + NW_W'(1);
                        state_q <= HOLD;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_inv_seq_ctrl
//
// Directed bench for inv_seq_ctrl. The cell under test is modelled as an
// ideal inverter. Its input pin can be forced low for a chosen window to
// create a single, predictable mismatch. Expected waveforms are derived from
// the programmed half-period and window count.
// ----------------------------------------------------------------------------
module tb_inv_seq_ctrl;

    localparam int HP_W = 16;
    localparam int NW_W = 8;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [HP_W-1:0] halfPeriod;
    logic [NW_W-1:0] numWindows;
    logic            mode;
    logic            dutA;
    logic            dutY;
    logic            busy;
    logic            done;
    logic            err;
    logic [NW_W-1:0] mismatchCnt;
    logic            stuckA;

    int checkCount = 0;
    int errorCount = 0;

    inv_seq_ctrl #(
        .HP_W(HP_W),
        .NW_W(NW_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .half_period (halfPeriod),
        .num_windows (numWindows),
        .mode        (mode),
        .dut_a       (dutA),
        .dut_y       (dutY),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .mismatch_cnt(mismatchCnt)
    );

    // Ideal inverter. While stuckA is set, its input pin reads as 0.
    assign dutY = ~(dutA & ~stuckA);

    // Free-running clock with a 10-time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just past the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One comparison. It counts the check and reports a failure.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checkCount++;
        assert (obs === exp)
        else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present the run settings and pulse start for one cycle. On return the
    // bench sits in cycle 1 of the run.
    task automatic applyStimulus(input int hpv, input int nwv, input logic modev);
        halfPeriod = HP_W'(hpv);
        numWindows = NW_W'(nwv);
        mode       = modev;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    // Run one sequence and check it cycle by cycle. stuckWin selects the
    // window in which the cell input is forced low (-1 for none).
    // reStartCycle re-pulses start mid-run with different settings (0 for
    // none).
    task automatic runAndCheck(input string name, input int hpv, input int nwv,
                               input logic modev, input int stuckWin,
                               input int reStartCycle, input logic expErr,
                               input int expCnt);
        int winLen;
        int total;
        int lastA;
        winLen = hpv + 1;
        total  = (hpv == 0 || nwv == 0) ? 0 : nwv * winLen;
        lastA  = (total == 0) ? 0 : (nwv - 1) % 2;
        applyStimulus(hpv, nwv, modev);
        for (int c = 1; c <= total; c++) begin
            int w;
            w = (c - 1) / winLen;
            stuckA = (w == stuckWin);
            if (c == reStartCycle) begin
                start      = 1'b1;
                halfPeriod = HP_W'(hpv + 5);
                numWindows = NW_W'(1);
            end else begin
                start = 1'b0;
            end
            #1;
            checkOutput($sformatf("%s dut_a c%0d", name, c), 32'(dutA), 32'(w % 2));
            checkOutput($sformatf("%s busy c%0d", name, c), 32'(busy), 32'd1);
            checkOutput($sformatf("%s done c%0d", name, c), 32'(done), 32'd0);
            step();
        end
        stuckA = 1'b0;
        start  = 1'b0;
        checkOutput({name, " done pulse"}, 32'(done), 32'd1);
        checkOutput({name, " busy in fin"}, 32'(busy), 32'd1);
        checkOutput({name, " dut_a final"}, 32'(dutA), 32'(lastA));
        step();
        checkOutput({name, " done low"}, 32'(done), 32'd0);
        checkOutput({name, " busy low"}, 32'(busy), 32'd0);
        checkOutput({name, " err"}, 32'(err), 32'(expErr));
        checkOutput({name, " mismatch_cnt"}, 32'(mismatchCnt), 32'(expCnt));
    endtask

    // Directed sequence: reset, the main runs, zero-length runs, a stuck
    // fault with recovery, an ignored mid-run start, and an aborting reset.
    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        halfPeriod = '0;
        numWindows = '0;
        mode       = 1'b0;
        stuckA     = 1'b0;

        step();
        step();
        checkOutput("reset dut_a", 32'(dutA), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset err", 32'(err), 32'd0);
        checkOutput("reset mismatch_cnt", 32'(mismatchCnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        runAndCheck("inv_ok", 3, 4, 1'b0, -1, 0, 1'b0, 0);
        step();
        runAndCheck("buf_mode", 2, 5, 1'b1, -1, 0, 1'b1, 5);
        step();
        runAndCheck("nw_zero", 3, 0, 1'b0, -1, 0, 1'b0, 0);
        step();
        runAndCheck("hp_zero", 0, 3, 1'b0, -1, 0, 1'b0, 0);
        step();
        runAndCheck("stuck_w1", 3, 4, 1'b0, 1, 0, 1'b1, 1);
        step();
        runAndCheck("recover", 3, 4, 1'b0, -1, 0, 1'b0, 0);
        step();
        runAndCheck("restart_ign", 2, 3, 1'b0, -1, 4, 1'b0, 0);
        step();

        // Buffer mode against the inverter gives a mismatch in every window.
        // By the second window err and the count are therefore non-zero.
        applyStimulus(3, 4, 1'b1);
        for (int c = 1; c < 6; c++) step();
        checkOutput("pre-abort dut_a", 32'(dutA), 32'd1);
        checkOutput("pre-abort err", 32'(err), 32'd1);
        checkOutput("pre-abort mismatch_cnt", 32'(mismatchCnt), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort dut_a", 32'(dutA), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort err", 32'(err), 32'd0);
        checkOutput("abort mismatch_cnt", 32'(mismatchCnt), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            checkOutput($sformatf("abort no done c%0d", c), 32'(done), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("post-abort idle done", 32'(done), 32'd0);
        runAndCheck("post_abort", 1, 3, 1'b0, -1, 0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
